// File: rtl/uart_transmitter.sv
// UART transmitter: 8 data bits LSB first, optional parity, 1 or 2 stop bits, one holding register.
// Define UART_TX_PARITY_EN to insert a parity bit (even, or odd when PARITY_ODD=1) after bit 7.
module uart_transmitter #(
    parameter int STOP_BITS  = 1,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       clk_50m_i,
    input  logic       rst_i,
    input  logic       clken_i,
    input  logic [7:0] din_8b_i,
    input  logic       din_valid_i,
    output logic       din_ready_o,
    output logic       tx_o,
    output logic       busy_o
);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd4
    } state_t;
`endif

    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

    state_t     state_q, state_d;
    logic [3:0] sample_q, sample_d;
    logic [2:0] bitpos_q, bitpos_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    logic       din_ready_q, din_ready_d;
    logic       tx_q, tx_d;
    logic       busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
    logic       parity_q, parity_d;
`endif

    logic accept;
    logic bit_end;

    assign accept  = din_valid_i & din_ready_q;
    assign bit_end = clken_i & (sample_q == 4'hF);

    always_comb begin
        state_d     = state_q;
        sample_d    = sample_q;
        bitpos_d    = bitpos_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        tx_d        = tx_q;
`ifdef UART_TX_PARITY_EN
        parity_d    = parity_q;
`endif

        if (accept) begin
            hold_d      = din_8b_i;
            hold_full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (hold_full_q) begin
                    state_d     = START;
                    shift_d     = hold_q;
                    hold_full_d = 1'b0;
                    tx_d        = 1'b0;
                    sample_d    = 4'd0;
                    bitpos_d    = 3'd0;
`ifdef UART_TX_PARITY_EN
                    parity_d    = (^hold_q) ^ PARITY_ODD;
`endif
                end
            end
            START: begin
                if (clken_i) sample_d = sample_q + 4'd1;
                if (bit_end) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (clken_i) sample_d = sample_q + 4'd1;
                if (bit_end) begin
                    if (bitpos_q == 3'd7) begin
                        bitpos_d = 3'd0;
`ifdef UART_TX_PARITY_EN
                        state_d  = PARITY;
                        tx_d     = parity_q;
`else
                        state_d  = STOP;
                        tx_d     = 1'b1;
`endif
                    end else begin
                        shift_d  = shift_q >> 1;
                        bitpos_d = bitpos_q + 3'd1;
                        tx_d     = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (clken_i) sample_d = sample_q + 4'd1;
                if (bit_end) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            // bitpos counts stop-bit periods here so two stop bits reuse the same sample counter
            STOP: begin
                if (clken_i) sample_d = sample_q + 4'd1;
                if (bit_end) begin
                    if (bitpos_q == STOP_LAST) begin
                        if (hold_full_q) begin
                            state_d     = START;
                            shift_d     = hold_q;
                            hold_full_d = 1'b0;
                            tx_d        = 1'b0;
                            sample_d    = 4'd0;
                            bitpos_d    = 3'd0;
`ifdef UART_TX_PARITY_EN
                            parity_d    = (^hold_q) ^ PARITY_ODD;
`endif
                        end else begin
                            state_d = IDLE;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bitpos_d = bitpos_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        din_ready_d = ~hold_full_q & ~accept;
        busy_d      = (state_q != IDLE) | hold_full_q;
    end

    always_ff @(posedge clk_50m_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            sample_q    <= 4'd0;
            bitpos_q    <= 3'd0;
            shift_q     <= 8'd0;
            hold_q      <= 8'd0;
            hold_full_q <= 1'b0;
            din_ready_q <= 1'b1;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sample_q    <= sample_d;
            bitpos_q    <= bitpos_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            din_ready_q <= din_ready_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    assign din_ready_o = din_ready_q;
    assign tx_o        = tx_q;
    assign busy_o      = busy_q;

endmodule
